// File: rtl/fdd_track_writeback_pkg.sv
// Shared definitions for the floppy track write-back engine.
// Holds the default track geometry, the sequencing state encoding, the
// track/sector/LBA widths and the track-to-LBA conversion helper.
package fdd_track_writeback_pkg;

  localparam int SECTORS   = 13;  // 512-byte SD sectors per floppy track
  localparam int TRACK_W   = 6;
  localparam int SEC_W     = 4;
  localparam int LBA_W     = 32;
  localparam int LBA_MUL_W = 10;  // width of track * SECTORS before zero-extension

  // Out-of-range track so the first real track request always loads.
  localparam logic [TRACK_W-1:0] TRACK_NONE = '1;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH_REQ,
    FLUSH_XFER,
    LOAD_REQ,
    LOAD_XFER
  } state_t;

  // First LBA of a track: product kept at 10 bits, then zero-extended.
  function automatic logic [LBA_W-1:0] track_lba(input logic [TRACK_W-1:0] track,
                                                 input int unsigned sectors);
    logic [LBA_MUL_W-1:0] prod;
    prod = LBA_MUL_W'(track) * LBA_MUL_W'(sectors);
    return LBA_W'(prod);
  endfunction

endpackage

// File: rtl/fdd_track_writeback_sd_sector_handshake.sv
// SD sector request/acknowledge sequencing.
// Ports:
//   clk_sys, reset_n  - clock, async active-low reset
//   req_active_i      - owning FSM sits in a request state
//   wr_sel_i          - 1 = write (flush) request, 0 = read (load) request
//   sd_ack_i          - SD acknowledge, high for one sector transfer
//   sd_rd_o, sd_wr_o  - sector read / write request
//   ack_rise_o        - sd_ack rising edge (request is taken)
//   ack_fall_o        - sd_ack falling edge (sector transfer finished)
module sd_sector_handshake (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req_active_i,
  input  logic wr_sel_i,
  input  logic sd_ack_i,
  output logic sd_rd_o,
  output logic sd_wr_o,
  output logic ack_rise_o,
  output logic ack_fall_o
);

  logic ack_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= sd_ack_i;
    end
  end

  assign ack_rise_o = sd_ack_i & ~ack_q;
  assign ack_fall_o = ~sd_ack_i & ack_q;

  // Requests decode straight from the registered request state, so they are
  // mutually exclusive and drop with the state on reset.
  assign sd_rd_o = req_active_i & ~wr_sel_i;
  assign sd_wr_o = req_active_i & wr_sel_i;

endmodule

// File: rtl/fdd_track_writeback.sv
// Floppy track buffer write-back / reload sequencer.
// Keeps one track of the disk image in a sector buffer. When the controller
// selects another track (or a new image is mounted) a dirty buffer is first
// written back to SD, then the requested track is read in, one 512-byte
// sector at a time, while the CPU is held in cpu_wait.
// Ports:
//   clk_sys, reset_n         - clock, async active-low reset
//   track_req                - track selected by the disk controller
//   buf_we                   - buffer write strobe (marks dirty in IDLE)
//   img_mounted              - one-cycle pulse, new image mounted
//   img_size_nz, img_readonly- mounted image properties
//   sd_ack                   - SD sector transfer acknowledge
//   sd_lba, sd_rd, sd_wr     - SD sector request
//   track_sec                - buffer sector index
//   cpu_wait                 - CPU stall while not IDLE
//   loaded_track, dirty      - buffer status
module fdd_track_writeback #(
  parameter int SECTORS = fdd_track_writeback_pkg::SECTORS
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [5:0]  track_req,
  input  logic        buf_we,
  input  logic        img_mounted,
  input  logic        img_size_nz,
  input  logic        img_readonly,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [3:0]  track_sec,
  output logic        cpu_wait,
  output logic [5:0]  loaded_track,
  output logic        dirty
);

  import fdd_track_writeback_pkg::*;

  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECTORS - 1);

  state_t               state_q;
  logic                 dirty_q;
  logic                 mount_pend_q;
  logic [TRACK_W-1:0]   loaded_track_q;
  logic [SEC_W-1:0]     track_sec_q;
  logic [LBA_W-1:0]     sd_lba_q;
  logic                 cpu_wait_q;

  logic ack_rise, ack_fall;
  logic last_sec, trigger, flush_ok;

  assign last_sec = (track_sec_q == LAST_SEC);
  assign trigger  = (track_req != loaded_track_q) | mount_pend_q;
  // A mount arriving this very cycle invalidates the buffer, so never flush it.
  assign flush_ok = dirty_q & ~img_mounted & ~img_readonly & img_size_nz;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      dirty_q        <= 1'b0;
      mount_pend_q   <= 1'b0;
      loaded_track_q <= TRACK_NONE;
      track_sec_q    <= '0;
      sd_lba_q       <= '0;
      cpu_wait_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (buf_we) dirty_q <= 1'b1;
          if (trigger) begin
            track_sec_q <= '0;
            if (flush_ok) begin
              state_q    <= FLUSH_REQ;
              sd_lba_q   <= track_lba(loaded_track_q, SECTORS);
              cpu_wait_q <= 1'b1;
            end else begin
              loaded_track_q <= track_req;
              mount_pend_q   <= 1'b0;
              if (img_size_nz) begin
                state_q    <= LOAD_REQ;
                sd_lba_q   <= track_lba(track_req, SECTORS);
                cpu_wait_q <= 1'b1;
              end
            end
          end
        end
        FLUSH_REQ: if (ack_rise) state_q <= FLUSH_XFER;
        FLUSH_XFER: begin
          if (ack_fall) begin
            // A mount abandons the rest of the flush once this sector is done.
            if (last_sec || mount_pend_q || img_mounted) begin
              state_q        <= LOAD_REQ;
              dirty_q        <= 1'b0;
              mount_pend_q   <= 1'b0;
              track_sec_q    <= '0;
              sd_lba_q       <= track_lba(track_req, SECTORS);
              loaded_track_q <= track_req;
            end else begin
              state_q     <= FLUSH_REQ;
              track_sec_q <= track_sec_q + 1'b1;
              sd_lba_q    <= sd_lba_q + 1'b1;
            end
          end
        end
        LOAD_REQ: if (ack_rise) state_q <= LOAD_XFER;
        LOAD_XFER: begin
          if (ack_fall) begin
            if (last_sec) begin
              state_q    <= IDLE;
              cpu_wait_q <= 1'b0;
            end else begin
              state_q     <= LOAD_REQ;
              track_sec_q <= track_sec_q + 1'b1;
              sd_lba_q    <= sd_lba_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          cpu_wait_q <= 1'b0;
        end
      endcase
      // Mount wins over buf_we and over any clear above.
      if (img_mounted) begin
        mount_pend_q <= 1'b1;
        dirty_q      <= 1'b0;
      end
    end
  end

  sd_sector_handshake u_handshake (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .req_active_i ((state_q == FLUSH_REQ) || (state_q == LOAD_REQ)),
    .wr_sel_i     (state_q == FLUSH_REQ),
    .sd_ack_i     (sd_ack),
    .sd_rd_o      (sd_rd),
    .sd_wr_o      (sd_wr),
    .ack_rise_o   (ack_rise),
    .ack_fall_o   (ack_fall)
  );

  assign sd_lba       = sd_lba_q;
  assign track_sec    = track_sec_q;
  assign cpu_wait     = cpu_wait_q;
  assign loaded_track = loaded_track_q;
  assign dirty        = dirty_q;

endmodule

// File: tb/tb_fdd_track_writeback.sv
// Testbench for fdd_track_writeback: a table of track-change scenarios
// applied in sequence, plus hand-written mount and reset corner cases.
// An SD responder acknowledges every request and logs {wr, lba, sector}.
module tb_fdd_track_writeback;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [5:0]  track_req;
  logic        buf_we;
  logic        img_mounted;
  logic        img_size_nz;
  logic        img_readonly;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic [5:0]  loaded_track;
  logic        dirty;

  int checks = 0;
  int failures = 0;

  bit          resp_en = 1'b1;
  int          mount_at = 0;
  bit          xfer_wr[$];
  logic [31:0] xfer_lba[$];
  logic [3:0]  xfer_sec[$];
  int          busy_cnt = 0;
  int          req_cnt = 0;
  int          viol = 0;

  typedef struct {
    bit         do_we;
    bit         ro;
    bit         nz;
    logic [5:0] trk;
    int         exp_wr;
    int         wr0;
    int         exp_rd;
    int         rd0;
    logic [5:0] exp_loaded;
    bit         exp_dirty;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[8];

  fdd_track_writeback dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .track_req    (track_req),
    .buf_we       (buf_we),
    .img_mounted  (img_mounted),
    .img_size_nz  (img_size_nz),
    .img_readonly (img_readonly),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .track_sec    (track_sec),
    .cpu_wait     (cpu_wait),
    .loaded_track (loaded_track),
    .dirty        (dirty)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // SD card model: ack one cycle after the request is seen, held three cycles.
  initial begin
    sd_ack = 1'b0;
    img_mounted = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (resp_en && (sd_rd || sd_wr)) begin
        xfer_wr.push_back(sd_wr);
        xfer_lba.push_back(sd_lba);
        xfer_sec.push_back(track_sec);
        @(negedge clk_sys);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        if (mount_at != 0 && mount_at == xfer_lba.size()) img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  // Protocol monitor.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (cpu_wait) busy_cnt++;
      if (sd_rd || sd_wr) req_cnt++;
      if (sd_rd && sd_wr) viol++;
      if ((sd_rd || sd_wr) && !cpu_wait) viol++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    int cyc;
    quiet = 0;
    cyc = 0;
    while (quiet < 4 && cyc < 3000) begin
      @(negedge clk_sys);
      cyc++;
      if (cpu_wait) quiet = 0;
      else quiet++;
    end
    chk({tag, "_idle"}, int'(quiet >= 4), 1);
  endtask

  // Expect nwr writes from LBA wr0 (sectors 0..), then nrd reads from rd0,
  // with reads wrapping every 13 sectors for back-to-back reloads.
  task automatic check_xfers(input int base, input int nwr, input int wr0,
                             input int nrd, input int rd0, input string tag);
    int n;
    int bad;
    int k;
    bit ew;
    int el;
    int es;
    n = xfer_lba.size() - base;
    bad = 0;
    chk({tag, "_nxfer"}, n, nwr + nrd);
    for (int i = 0; i < n; i++) begin
      if (i < nwr) begin
        ew = 1'b1;
        el = wr0 + i;
        es = i;
      end else begin
        k  = i - nwr;
        ew = 1'b0;
        el = rd0 + (k % 13);
        es = k % 13;
      end
      if (xfer_wr[base+i] != ew || xfer_lba[base+i] != 32'(el) || xfer_sec[base+i] != 4'(es))
        bad++;
    end
    chk({tag, "_seq_bad"}, bad, 0);
  endtask

  initial begin
    int base;
    int b0;
    int r0;
    int cyc;
    string tag;

    //          we ro nz trk  nwr wr0 nrd rd0  loaded dirty busy
    vecs[0] = '{1'b0, 1'b0, 1'b1, 6'd5,  0,  0,   13, 65,  6'd5,  1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 6'd6,  13, 65,  13, 78,  6'd6,  1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 6'd5,  0,  0,   13, 65,  6'd5,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 6'd6,  0,  0,   13, 78,  6'd6,  1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 6'd34, 13, 78,  13, 442, 6'd34, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'd40, 0,  0,   0,  0,   6'd40, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 6'd41, 0,  0,   0,  0,   6'd41, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 6'd63, 13, 533, 13, 819, 6'd63, 1'b0, 1'b1};

    reset_n = 1'b0;
    track_req = 6'd0;
    buf_we = 1'b0;
    img_size_nz = 1'b1;
    img_readonly = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk_sys);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_loaded", loaded_track, 63);
    chk("rst_lba", sd_lba, 0);
    chk("rst_sec", track_sec, 0);

    // First load after reset: track 0, LBA 0..12.
    base = xfer_lba.size();
    reset_n = 1'b1;
    wait_idle("boot");
    check_xfers(base, 0, 0, 13, 0, "boot");
    chk("boot_loaded", loaded_track, 0);
    chk("boot_cpu_wait", cpu_wait, 0);

    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("v%0d", i);
      @(negedge clk_sys);
      img_readonly = vecs[i].ro;
      img_size_nz = vecs[i].nz;
      if (vecs[i].do_we) begin
        @(negedge clk_sys);
        buf_we = 1'b1;
        @(negedge clk_sys);
        buf_we = 1'b0;
      end
      @(negedge clk_sys);
      base = xfer_lba.size();
      b0 = busy_cnt;
      track_req = vecs[i].trk;
      wait_idle(tag);
      check_xfers(base, vecs[i].exp_wr, vecs[i].wr0, vecs[i].exp_rd, vecs[i].rd0, tag);
      chk({tag, "_loaded"}, loaded_track, vecs[i].exp_loaded);
      chk({tag, "_dirty"}, dirty, vecs[i].exp_dirty);
      chk({tag, "_busy"}, int'(busy_cnt != b0), vecs[i].exp_busy);
    end

    // Mount while the 4th flush sector is in flight.
    @(negedge clk_sys);
    buf_we = 1'b1;
    @(negedge clk_sys);
    buf_we = 1'b0;
    @(negedge clk_sys);
    chk("mflush_dirty_set", dirty, 1);
    base = xfer_lba.size();
    mount_at = base + 4;
    track_req = 6'd10;
    wait_idle("mflush");
    mount_at = 0;
    check_xfers(base, 4, 819, 13, 130, "mflush");
    chk("mflush_loaded", loaded_track, 10);
    chk("mflush_dirty", dirty, 0);
    r0 = req_cnt;
    repeat (20) @(negedge clk_sys);
    chk("mflush_no_retrig", req_cnt - r0, 0);

    // Mount during a load: finish it, then reload the same track.
    @(negedge clk_sys);
    base = xfer_lba.size();
    mount_at = base + 2;
    track_req = 6'd11;
    wait_idle("mload");
    mount_at = 0;
    check_xfers(base, 0, 0, 26, 143, "mload");
    chk("mload_loaded", loaded_track, 11);

    // Reset while a read request is pending (readonly keeps the buffer dirty).
    @(negedge clk_sys);
    resp_en = 1'b0;
    img_readonly = 1'b1;
    buf_we = 1'b1;
    @(negedge clk_sys);
    buf_we = 1'b0;
    track_req = 6'd20;
    cyc = 0;
    while (!sd_rd && cyc < 20) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("rst2_rd_pending", sd_rd, 1);
    chk("rst2_dirty_before", dirty, 1);
    reset_n = 1'b0;
    #1;
    chk("rst2_sd_rd", sd_rd, 0);
    chk("rst2_cpu_wait", cpu_wait, 0);
    chk("rst2_dirty", dirty, 0);
    chk("rst2_loaded", loaded_track, 63);
    chk("rst2_lba", sd_lba, 0);
    chk("rst2_sec", track_sec, 0);
    track_req = 6'h3F;
    img_readonly = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    r0 = req_cnt;
    b0 = busy_cnt;
    repeat (20) @(negedge clk_sys);
    chk("rst2_no_req", req_cnt - r0, 0);
    chk("rst2_no_busy", busy_cnt - b0, 0);
    resp_en = 1'b1;
    base = xfer_lba.size();
    track_req = 6'd0;
    wait_idle("rst2_load");
    check_xfers(base, 0, 0, 13, 0, "rst2_load");
    chk("rst2_load_loaded", loaded_track, 0);

    chk("protocol_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
